inst_fetch_queue: RTL and testbench

//   Parametrised fetch front-end; replaces the separate PC and IF_ID blocks of the core.

---
 rtl/inst_fetch_queue.sv | 140 ++++++++++++++
 tb/tb_inst_fetch_queue.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: fetch front-end driving a 1-cycle synchronous instruction ROM.
// Holds the PC, tracks one in-flight ROM read, and buffers {addr, inst} pairs in a
// DEPTH-entry FIFO whose head is presented to ID with a valid/stall handshake.
// A redirect flushes the FIFO and the in-flight read and restarts fetch at a new PC.
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   rom_en, rom_addr          fetch request and address (address = PC register)
//   rom_inst                  ROM data, valid the cycle after rom_en
//   redirect_en/_addr         flush and restart fetch at redirect_addr
//   stall                     ID cannot accept the head this cycle
//   id_valid/_addr/_inst      head entry; addr/inst forced to 0 when empty
//   fifo_count                occupied FIFO entries
// Build option FETCH_PERF_EN adds perf_bubble_cnt (cycles with id_valid=0) and
// perf_flush_cnt (redirect cycles), both 32-bit saturating, cleared by rst.
module inst_fetch_queue #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INST_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    PC_STEP    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    rom_en,
    output logic [ADDR_WIDTH-1:0]   rom_addr,
    input  logic [INST_WIDTH-1:0]   rom_inst,
    input  logic                    redirect_en,
    input  logic [ADDR_WIDTH-1:0]   redirect_addr,
    input  logic                    stall,
    output logic                    id_valid,
    output logic [ADDR_WIDTH-1:0]   id_addr,
    output logic [INST_WIDTH-1:0]   id_inst,
    output logic [$clog2(DEPTH):0]  fifo_count
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]             perf_bubble_cnt,
    output logic [31:0]             perf_flush_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] LP_DEPTH = (CW+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_inflight;
    logic [ADDR_WIDTH-1:0] r_inflight_addr;
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_wr_ptr;
    logic [CW-1:0]         r_count;
    logic [ADDR_WIDTH-1:0] r_mem_addr [DEPTH];
    logic [INST_WIDTH-1:0] r_mem_inst [DEPTH];

    logic                  w_valid;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_issue;
    logic [CW:0]           w_occ;

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid & ~stall & ~redirect_en;
    assign w_push  = r_inflight & ~redirect_en;

    // Credit check: entries held plus the read in flight, minus the one
    // leaving this cycle, must leave room for the read issued now.
    assign w_occ   = {1'b0, r_count}
                   + {{CW{1'b0}}, r_inflight}
                   - {{CW{1'b0}}, w_pop};
    assign w_issue = ~rst & ~redirect_en & (w_occ < LP_DEPTH);

    assign rom_en     = w_issue;
    assign rom_addr   = r_pc;
    assign id_valid   = w_valid;
    assign id_addr    = w_valid ? r_mem_addr[r_rd_ptr] : '0;
    assign id_inst    = w_valid ? r_mem_inst[r_rd_ptr] : '0;
    assign fifo_count = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc            <= RESET_PC;
            r_inflight      <= 1'b0;
            r_inflight_addr <= '0;
            r_rd_ptr        <= '0;
            r_wr_ptr        <= '0;
            r_count         <= '0;
        end else if (redirect_en) begin
            // The ROM response due next cycle belongs to the old path.
            r_pc       <= redirect_addr;
            r_inflight <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_addr <= r_pc;
                r_pc            <= r_pc + ADDR_WIDTH'(PC_STEP);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{(CW-1){1'b0}}, w_push}
                               - {{(CW-1){1'b0}}, w_pop};
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= r_inflight_addr;
            r_mem_inst[r_wr_ptr] <= rom_inst;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (!w_valid && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
            if (redirect_en && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign perf_bubble_cnt = r_bubble_cnt;
    assign perf_flush_cnt  = r_flush_cnt;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: scoreboard bench for inst_fetch_queue (DEPTH=4 and DEPTH=2
// instances sharing stimulus), each with a ROM model where ROM[addr>>2] = addr>>2.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        stall = 1'b0;

    logic        rom_en1, rom_en2;
    logic [31:0] rom_addr1, rom_addr2;
    logic [31:0] rom_inst1 = '0, rom_inst2 = '0;
    logic        v1, v2;
    logic [31:0] a1, a2, i1, i2;
    logic [2:0]  cnt1;
    logic [1:0]  cnt2;
`ifdef FETCH_PERF_EN
    logic [31:0] pb1, pf1, pb2, pf2;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic [63:0] sb1[$];
    logic [63:0] sb2[$];

    always #5 clk = ~clk;

    inst_fetch_queue #(.DEPTH(4)) u1 (
        .clk(clk), .rst(rst),
        .rom_en(rom_en1), .rom_addr(rom_addr1), .rom_inst(rom_inst1),
        .redirect_en(redirect_en), .redirect_addr(redirect_addr),
        .stall(stall),
        .id_valid(v1), .id_addr(a1), .id_inst(i1),
        .fifo_count(cnt1)
`ifdef FETCH_PERF_EN
        , .perf_bubble_cnt(pb1), .perf_flush_cnt(pf1)
`endif
    );

    inst_fetch_queue #(.DEPTH(2)) u2 (
        .clk(clk), .rst(rst),
        .rom_en(rom_en2), .rom_addr(rom_addr2), .rom_inst(rom_inst2),
        .redirect_en(redirect_en), .redirect_addr(redirect_addr),
        .stall(stall),
        .id_valid(v2), .id_addr(a2), .id_inst(i2),
        .fifo_count(cnt2)
`ifdef FETCH_PERF_EN
        , .perf_bubble_cnt(pb2), .perf_flush_cnt(pf2)
`endif
    );

    // Synchronous ROMs, 1-cycle latency
    always @(posedge clk) begin
        if (rom_en1) rom_inst1 <= {2'b00, rom_addr1[31:2]};
        if (rom_en2) rom_inst2 <= {2'b00, rom_addr2[31:2]};
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load(input logic [31:0] base, input int n);
        logic [31:0] a;
        sb1.delete();
        sb2.delete();
        for (int k = 0; k < n; k++) begin
            a = base + 32'(4 * k);
            sb1.push_back({a, 2'b00, a[31:2]});
            sb2.push_back({a, 2'b00, a[31:2]});
        end
    endtask

    // Monitor: every accepted head is compared to the scoreboard.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst) begin
            chk("u1_count_bound", 64'(cnt1 <= 3'd4), 64'd1);
            chk("u2_count_bound", 64'(cnt2 <= 2'd2), 64'd1);
            if (v1 && !stall && !redirect_en) begin
                if (sb1.size() == 0) begin
                    chk("u1_unexpected_pop", {a1, i1}, 64'd0);
                end else begin
                    e = sb1.pop_front();
                    chk("u1_stream", {a1, i1}, e);
                end
            end
            if (v2 && !stall && !redirect_en) begin
                if (sb2.size() == 0) begin
                    chk("u2_unexpected_pop", {a2, i2}, 64'd0);
                end else begin
                    e = sb2.pop_front();
                    chk("u2_stream", {a2, i2}, e);
                end
            end
        end
    end

`ifdef FETCH_PERF_EN
    int  m_bub = 0;
    int  m_fl  = 0;
    bit  s_bub = 0;
    bit  s_fl  = 0;
    always @(negedge clk) begin
        s_bub = !v1;
        s_fl  = redirect_en;
    end
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_bub = 0;
            m_fl  = 0;
        end else begin
            if (s_bub) m_bub++;
            if (s_fl) m_fl++;
        end
    end
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            tick();
            @(negedge clk);
            chk({tag, "_v1"}, 64'(v1), 64'd1);
            chk({tag, "_v2"}, 64'(v2), 64'd1);
        end
    endtask

    task automatic outs_zero(input string tag);
        chk({tag, "_rom_en"}, 64'({rom_en1, rom_en2}), 64'd0);
        chk({tag, "_id_valid"}, 64'({v1, v2}), 64'd0);
        chk({tag, "_id1"}, {a1, i1}, 64'd0);
        chk({tag, "_id2"}, {a2, i2}, 64'd0);
        chk({tag, "_count"}, 64'({cnt1, cnt2}), 64'd0);
        chk({tag, "_rom_addr"}, 64'(rom_addr1), 64'd0);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        outs_zero("reset");

        // 1: release, latency and first stream
        tick();
        load(32'h0, 40);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_rom_en", 64'(rom_en1), 64'd1);
        chk("rel_rom_addr0", 64'(rom_addr1), 64'h0);
        chk("rel_valid_c0", 64'(v1), 64'd0);
        tick();
        @(negedge clk);
        chk("rel_valid_c1", 64'(v1), 64'd0);
        chk("rel_rom_addr1", 64'(rom_addr1), 64'h4);
        tick();
        @(negedge clk);
        chk("rel_valid_c2", 64'(v1), 64'd1);
        chk("rel_valid_c2_d2", 64'(v2), 64'd1);
        stream(6, "t1");

        // 2: reset mid-run, then fill while stalled
        tick();
        rst   = 1'b1;
        stall = 1'b1;
        #1;
        outs_zero("midrst");
        load(32'h0, 40);
        tick();
        rst = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        chk("full_cnt1", 64'(cnt1), 64'd4);
        chk("full_cnt2", 64'(cnt2), 64'd2);
        chk("full_rom_en", 64'({rom_en1, rom_en2}), 64'd0);
        chk("full_head1", {a1, i1}, 64'h0);
        chk("full_head2", {a2, i2}, 64'h0);
        tick();
        stall = 1'b0;
        stream(8, "t2");

        // 3: redirect while streaming
        tick();
        redirect_en   = 1'b1;
        redirect_addr = 32'h100;
        load(32'h100, 30);
        @(negedge clk);
        chk("rd_rom_en", 64'({rom_en1, rom_en2}), 64'd0);
        tick();
        redirect_en = 1'b0;
        @(negedge clk);
        chk("rd_cnt", 64'({cnt1, cnt2}), 64'd0);
        chk("rd_valid", 64'({v1, v2}), 64'd0);
        chk("rd_rom_addr", 64'(rom_addr1), 64'h100);
        tick();
        @(negedge clk);
        chk("rd_valid_c1", 64'(v1), 64'd0);
        tick();
        @(negedge clk);
        chk("rd_valid_c2", 64'(v1), 64'd1);
        chk("rd_head", {a1, i1}, {32'h100, 32'h40});
        stream(5, "t3");

        // 4: redirect with stall and full FIFO
        tick();
        stall = 1'b1;
        repeat (5) tick();
        redirect_en   = 1'b1;
        redirect_addr = 32'h200;
        load(32'h200, 30);
        @(negedge clk);
        chk("rs_full_cnt1", 64'(cnt1), 64'd4);
        tick();
        redirect_en = 1'b0;
        stall       = 1'b0;
        @(negedge clk);
        chk("rs_cnt", 64'({cnt1, cnt2}), 64'd0);
        chk("rs_rom_addr", 64'(rom_addr1), 64'h200);
        tick();
        tick();
        @(negedge clk);
        chk("rs_head", {a1, i1}, {32'h200, 32'h80});
        stream(4, "t4");

        // 5: PC wrap, with stalled cycles while empty
        tick();
        redirect_en   = 1'b1;
        redirect_addr = 32'hFFFF_FFFC;
        load(32'hFFFF_FFFC, 30);
        tick();
        redirect_en = 1'b0;
        stall       = 1'b1;
        @(negedge clk);
        chk("wrap_rom_addr0", 64'(rom_addr1), 64'hFFFF_FFFC);
        tick();
        @(negedge clk);
        chk("wrap_rom_addr1", 64'(rom_addr1), 64'h0);
        chk("wrap_rom_addr1_d2", 64'(rom_addr2), 64'h0);
        repeat (3) tick();
        stall = 1'b0;
        @(negedge clk);
        chk("wrap_head", {a1, i1}, {32'hFFFF_FFFC, 32'h3FFF_FFFF});
        stream(6, "t5");

`ifdef FETCH_PERF_EN
        // 6: performance counters
        @(negedge clk);
        chk("perf_flush1", 64'(pf1), 64'd3);
        chk("perf_flush2", 64'(pf2), 64'd3);
        chk("perf_bubble1", 64'(pb1), 64'(m_bub));
        tick();
        rst = 1'b1;
        #1;
        outs_zero("perfrst");
        chk("perf_clr", {pb1, pf1}, 64'd0);
        chk("perf_clr2", {pb2, pf2}, 64'd0);
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
